// File: rtl/rbm_vote_controller.sv
// Iteration controller and vote accumulator for the stochastic RBM layer pair.
// Runs a runtime number of layer iterations, accumulating saturating per-class votes, with optional early stop on margin.
module rbm_vote_controller #(
  parameter int output_dim = 10,
  parameter int bitlength  = 12,
  parameter int iter_width = 10,
  parameter int win_width  = 4
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             abort,
  input  logic [iter_width-1:0]            iteration_num,
  input  logic [bitlength-1:0]             early_margin,
  input  logic                             layer_finish,
  input  logic [output_dim-1:0]            layer_spikes,
  output logic                             layer_reset,
  output logic                             busy,
  output logic                             done,
  output logic                             early_exit,
  output logic [iter_width-1:0]            iterations_done,
  output logic [win_width-1:0]             winner,
  output logic [output_dim*bitlength-1:0]  vote_counts
);

  typedef enum logic [2:0] {IDLE, RST_L, RUN, ACCUM, CHECK, DONE} state_t;

  state_t                 state_q, state_d;
  logic [bitlength-1:0]   count_q [output_dim];
  logic [bitlength-1:0]   count_d [output_dim];
  logic [iter_width-1:0]  iter_q, iter_d;
  logic [iter_width-1:0]  iter_max_q, iter_max_d;
  logic [bitlength-1:0]   margin_q, margin_d;
  logic [win_width-1:0]   winner_q, winner_d;
  logic                   done_q, done_d;
  logic                   early_q, early_d;
  logic [output_dim-1:0]  spikes_q, spikes_d;

  int                     top_pos;
  logic [bitlength-1:0]   top_val;
  logic [bitlength-1:0]   second_val;
  logic [bitlength-1:0]   lead;
  logic                   count_hit;
  logic                   margin_hit;

  // Argmax with lowest-index tie break; runner-up excludes only the winning index, so a tie gives lead 0.
  always_comb begin
    top_pos    = 0;
    top_val    = count_q[0];
    second_val = '0;
    for (int i = 1; i < output_dim; i++) begin
      if (count_q[i] > top_val) begin
        top_val = count_q[i];
        top_pos = i;
      end
    end
    for (int i = 0; i < output_dim; i++) begin
      if (i != top_pos && count_q[i] > second_val) second_val = count_q[i];
    end
    lead       = top_val - second_val;
    count_hit  = (iter_q == iter_max_q);
    margin_hit = (margin_q != '0) && (lead >= margin_q);
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    iter_d     = iter_q;
    iter_max_d = iter_max_q;
    margin_d   = margin_q;
    winner_d   = winner_q;
    done_d     = done_q;
    early_d    = early_q;
    spikes_d   = spikes_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          for (int i = 0; i < output_dim; i++) count_d[i] = '0;
          iter_d     = '0;
          done_d     = 1'b0;
          early_d    = 1'b0;
          iter_max_d = iteration_num;
          margin_d   = early_margin;
          if (iteration_num == '0) begin
            state_d  = DONE;
            winner_d = '0;
            done_d   = 1'b1;
          end else begin
            state_d  = RST_L;
          end
        end
      end
      RST_L: state_d = abort ? IDLE : RUN;
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (layer_finish) begin
          spikes_d = layer_spikes;
          state_d  = ACCUM;
        end
      end
      ACCUM: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          for (int i = 0; i < output_dim; i++) begin
            if (spikes_q[i] && (count_q[i] != {bitlength{1'b1}}))
              count_d[i] = count_q[i] + bitlength'(1);
          end
          iter_d  = iter_q + iter_width'(1);
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (abort) begin
          state_d = IDLE;
        end else if (count_hit || margin_hit) begin
          winner_d = win_width'(top_pos);
          early_d  = !count_hit;
          done_d   = 1'b1;
          state_d  = DONE;
        end else begin
          state_d  = RST_L;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      for (int i = 0; i < output_dim; i++) count_q[i] <= '0;
      iter_q     <= '0;
      iter_max_q <= '0;
      margin_q   <= '0;
      winner_q   <= '0;
      done_q     <= 1'b0;
      early_q    <= 1'b0;
      spikes_q   <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      iter_q     <= iter_d;
      iter_max_q <= iter_max_d;
      margin_q   <= margin_d;
      winner_q   <= winner_d;
      done_q     <= done_d;
      early_q    <= early_d;
      spikes_q   <= spikes_d;
    end
  end

  always_comb begin
    vote_counts = '0;
    for (int i = 0; i < output_dim; i++) vote_counts[i*bitlength +: bitlength] = count_q[i];
  end

  assign layer_reset     = !((state_q == RUN) || (state_q == ACCUM));
  assign busy            = (state_q == RST_L) || (state_q == RUN) ||
                           (state_q == ACCUM) || (state_q == CHECK);
  assign done            = done_q;
  assign early_exit      = early_q;
  assign iterations_done = iter_q;
  assign winner          = winner_q;

endmodule

// File: tb/tb_rbm_vote_controller.sv
// Self-checking bench: a 12-bit and a 4-bit counter instance share stimulus; a behavioural
// layer model answers each layer_reset release, and expected run results go through a scoreboard queue.
module tb_rbm_vote_controller;

  localparam int OD  = 10;
  localparam int LAT = 3;

  logic            clock;
  logic            reset;
  logic            start;
  logic            abort;
  logic [9:0]      iteration_num;
  logic [11:0]     early_margin;
  logic [OD-1:0]   model_spikes;

  logic            layer_finish, layer_finish4;
  logic            layer_reset, layer_reset4;
  logic            busy, busy4, done, done4, early_exit, early_exit4;
  logic [9:0]      iterations_done, iterations_done4;
  logic [3:0]      winner, winner4;
  logic [OD*12-1:0] vote_counts;
  logic [OD*4-1:0]  vote_counts4;
  logic [3:0]      lcnt, lcnt4;

  int checks = 0;
  int errors = 0;
  int lastWait;
  bit sawLayerLow;

  typedef struct {
    int which;
    int winner;
    int iters;
    int early;
    int cnt [OD];
  } exp_t;

  exp_t sb [$];

  rbm_vote_controller dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .iteration_num(iteration_num), .early_margin(early_margin),
    .layer_finish(layer_finish), .layer_spikes(model_spikes),
    .layer_reset(layer_reset), .busy(busy), .done(done), .early_exit(early_exit),
    .iterations_done(iterations_done), .winner(winner), .vote_counts(vote_counts)
  );

  rbm_vote_controller #(.bitlength(4)) dut4 (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .iteration_num(iteration_num), .early_margin(early_margin[3:0]),
    .layer_finish(layer_finish4), .layer_spikes(model_spikes),
    .layer_reset(layer_reset4), .busy(busy4), .done(done4), .early_exit(early_exit4),
    .iterations_done(iterations_done4), .winner(winner4), .vote_counts(vote_counts4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Layer model: finish rises LAT cycles after layer_reset is released and holds until reset again.
  always @(posedge clock) begin
    if (layer_reset) begin
      lcnt <= '0;
      layer_finish <= 1'b0;
    end else begin
      lcnt <= lcnt + 4'd1;
      if (lcnt == LAT - 1) layer_finish <= 1'b1;
    end
  end

  always @(posedge clock) begin
    if (layer_reset4) begin
      lcnt4 <= '0;
      layer_finish4 <= 1'b0;
    end else begin
      lcnt4 <= lcnt4 + 4'd1;
      if (lcnt4 == LAT - 1) layer_finish4 <= 1'b1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
    end
  endtask

  // Reference run: constant spike pattern each iteration, saturating at maxv.
  function automatic exp_t modelRun(int which, int n, int margin, logic [OD-1:0] spk, int maxv);
    exp_t e;
    int top, runner, lead;
    e.which = which;
    e.winner = 0;
    e.iters = 0;
    e.early = 0;
    for (int i = 0; i < OD; i++) e.cnt[i] = 0;
    for (int k = 1; k <= n; k++) begin
      for (int i = 0; i < OD; i++)
        if (spk[i] && e.cnt[i] < maxv) e.cnt[i]++;
      e.iters = k;
      top = 0;
      for (int i = 1; i < OD; i++) if (e.cnt[i] > e.cnt[top]) top = i;
      runner = 0;
      for (int i = 0; i < OD; i++) if (i != top && e.cnt[i] > runner) runner = e.cnt[i];
      lead = e.cnt[top] - runner;
      if (k == n) begin
        e.winner = top;
        break;
      end
      if (margin != 0 && lead >= margin) begin
        e.winner = top;
        e.early = 1;
        break;
      end
    end
    return e;
  endfunction

  task automatic compareResult();
    exp_t e;
    string p;
    e = sb.pop_front();
    p = (e.which == 0) ? "w12" : "w4";
    if (e.which == 0) begin
      checkOutput({p, "_done"}, 32'(done), 1);
      checkOutput({p, "_winner"}, 32'(winner), e.winner);
      checkOutput({p, "_iters"}, 32'(iterations_done), e.iters);
      checkOutput({p, "_early"}, 32'(early_exit), e.early);
      checkOutput({p, "_busy"}, 32'(busy), 0);
      for (int i = 0; i < OD; i++)
        checkOutput($sformatf("%s_count%0d", p, i), 32'(vote_counts[i*12 +: 12]), e.cnt[i]);
    end else begin
      checkOutput({p, "_done"}, 32'(done4), 1);
      checkOutput({p, "_winner"}, 32'(winner4), e.winner);
      checkOutput({p, "_iters"}, 32'(iterations_done4), e.iters);
      checkOutput({p, "_early"}, 32'(early_exit4), e.early);
      for (int i = 0; i < OD; i++)
        checkOutput($sformatf("%s_count%0d", p, i), 32'(vote_counts4[i*4 +: 4]), e.cnt[i]);
    end
  endtask

  task automatic pulseStart(input int n, input int margin, input logic [OD-1:0] spk);
    iteration_num = 10'(n);
    early_margin  = 12'(margin);
    model_spikes  = spk;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Full run through the scoreboard; poke re-asserts start mid-run with a different count.
  task automatic applyStimulus(input int n, input int margin, input logic [OD-1:0] spk, input bit poke);
    sb.push_back(modelRun(0, n, margin, spk, 4095));
    sb.push_back(modelRun(1, n, margin & 15, spk, 15));
    pulseStart(n, margin, spk);
    lastWait = 0;
    sawLayerLow = 0;
    if (poke) begin
      repeat (3) @(negedge clock);
      lastWait = 3;
      iteration_num = 10'd1;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      iteration_num = 10'(n);
    end
    while (!(done && done4) && lastWait < 3000) begin
      if (!layer_reset) sawLayerLow = 1;
      @(negedge clock);
      lastWait++;
    end
    checkOutput("run_completed", 32'(done && done4), 1);
    compareResult();
    compareResult();
  endtask

  task automatic waitRun(input int iters);
    int guard = 0;
    while (!(iterations_done == 10'(iters) && !layer_reset) && guard < 1000) begin
      @(negedge clock);
      guard++;
    end
    checkOutput("reach_run", 32'(guard < 1000), 1);
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    iteration_num = '0;
    early_margin = '0;
    model_spikes = '0;
    repeat (3) @(negedge clock);
    checkOutput("rst_layer_reset", 32'(layer_reset), 1);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_done", 32'(done), 0);
    checkOutput("rst_early", 32'(early_exit), 0);
    checkOutput("rst_iters", 32'(iterations_done), 0);
    checkOutput("rst_winner", 32'(winner), 0);
    checkOutput("rst_counts", 32'(vote_counts == '0), 1);
    reset = 1'b1;
    @(negedge clock);

    $display("[TB] fixed count, class 2");
    applyStimulus(3, 0, 10'b0000000100, 0);

    $display("[TB] early margin, class 7");
    applyStimulus(100, 5, 10'b0010000000, 0);

    $display("[TB] zero iterations");
    applyStimulus(0, 0, 10'b0010000000, 0);
    checkOutput("zero_latency", 32'(lastWait), 0);
    checkOutput("zero_layer_low", 32'(sawLayerLow), 0);
    checkOutput("zero_layer_reset", 32'(layer_reset), 1);

    $display("[TB] saturation, class 0");
    applyStimulus(20, 0, 10'b0000000001, 0);

    $display("[TB] abort in second iteration");
    pulseStart(10, 0, 10'b0000010001);
    waitRun(1);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    checkOutput("abort_busy", 32'(busy), 0);
    checkOutput("abort_layer_reset", 32'(layer_reset), 1);
    checkOutput("abort_done", 32'(done), 0);
    checkOutput("abort_iters", 32'(iterations_done), 1);
    checkOutput("abort_count0", 32'(vote_counts[0 +: 12]), 1);
    repeat (2) @(negedge clock);
    checkOutput("abort_idle_layer_reset", 32'(layer_reset), 1);
    applyStimulus(2, 0, 10'b1000000000, 0);

    $display("[TB] tie with start while busy");
    applyStimulus(4, 0, 10'b0000101000, 1);

    $display("[TB] reset mid-run");
    pulseStart(10, 0, 10'b0000000010);
    waitRun(1);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    checkOutput("mrst_layer_reset", 32'(layer_reset), 1);
    checkOutput("mrst_busy", 32'(busy), 0);
    checkOutput("mrst_done", 32'(done), 0);
    checkOutput("mrst_early", 32'(early_exit), 0);
    checkOutput("mrst_iters", 32'(iterations_done), 0);
    checkOutput("mrst_winner", 32'(winner), 0);
    checkOutput("mrst_counts", 32'(vote_counts == '0), 1);
    checkOutput("mrst_counts4", 32'(vote_counts4 == '0), 1);
    @(negedge clock);
    checkOutput("mrst_stays_idle", 32'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
